block_state_store: RTL

BLOCK_STATE_STORE -- requirements
Module: block_state_store

---
 rtl/block_state_store.sv | 117 +++++++++++
 1 files changed

// File: rtl/block_state_store.sv
// block_state_store: per-block presence board with row scan-out, hit handling and pattern reload
module block_state_store #(
    parameter int BLOCKS_PER_ROW = 13,
    parameter int NUM_ROWS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      new_frame,
    input  logic                      go_next_line,
    output logic [BLOCKS_PER_ROW-1:0] block_line_state,
    input  logic                      level_load,
    input  logic [1:0]                level_pattern,
    input  logic                      hit_valid,
    input  logic [3:0]                hit_row,
    input  logic [3:0]                hit_col,
    output logic                      hit_ready,
    output logic                      hit_done,
    output logic                      hit_present,
    output logic [7:0]                blocks_left,
    output logic                      all_cleared
);
    localparam int RW = $clog2(NUM_ROWS);
    localparam logic [4:0] NROWS    = 5'(NUM_ROWS);
    localparam logic [4:0] LAST_ROW = 5'(NUM_ROWS - 1);
    localparam logic [4:0] NCOLS    = 5'(BLOCKS_PER_ROW);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t                    state, state_next;
    logic [BLOCKS_PER_ROW-1:0] rows [NUM_ROWS];
    logic [4:0]                ptr;
    logic [4:0]                load_row;
    logic [1:0]                pattern;
    logic [BLOCKS_PER_ROW-1:0] fill_row;
    logic [7:0]                fill_count;
    logic                      accept;
    logic                      in_range;
    logic                      old_bit;

    assign hit_ready        = (state == IDLE) && !level_load;
    assign accept           = hit_valid && hit_ready;
    assign in_range         = ({1'b0, hit_col} < NCOLS) && ({1'b0, hit_row} < NROWS);
    assign all_cleared      = (state == IDLE) && (blocks_left == 8'd0);
    assign block_line_state = (state == IDLE && ptr < NROWS) ? rows[ptr[RW-1:0]] : '0;

    // Old presence bit at the hit location; out-of-range hits read as empty
    always_comb begin
        old_bit = 1'b0;
        if (in_range)
            old_bit = rows[hit_row[RW-1:0]][hit_col];
    end

    // Fill word and its popcount for the row currently being loaded
    always_comb begin
        fill_row   = '0;
        fill_count = 8'd0;
        for (int c = 0; c < BLOCKS_PER_ROW; c++) begin
            case (pattern)
                2'd0:    fill_row[c] = 1'b1;
                2'd1:    fill_row[c] = ~(load_row[0] ^ c[0]);
                2'd2:    fill_row[c] = ~load_row[0];
                default: fill_row[c] = (load_row >= 5'd4);
            endcase
            fill_count = fill_count + {7'b0, fill_row[c]};
        end
    end

    // State register; reset lands in LOAD so the board self-fills
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= LOAD;
        else
            state <= state_next;
    end

    // Next state: enter LOAD on a refill request, leave after the last row
    always_comb begin
        state_next = state;
        if (state == IDLE && level_load)
            state_next = LOAD;
        else if (state == LOAD && load_row == LAST_ROW)
            state_next = IDLE;
    end

    // Board storage, counters, row pointer and hit response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ROWS; i++)
                rows[i] <= '0;
            ptr         <= 5'd0;
            load_row    <= 5'd0;
            pattern     <= 2'd0;
            blocks_left <= 8'd0;
            hit_done    <= 1'b0;
            hit_present <= 1'b0;
        end else begin
            hit_done    <= accept;
            hit_present <= accept && old_bit;
            if (new_frame)
                ptr <= 5'd0;
            else if (go_next_line && ptr < NROWS)
                ptr <= ptr + 5'd1;
            if (state == IDLE && level_load) begin
                pattern     <= level_pattern;
                blocks_left <= 8'd0;
                load_row    <= 5'd0;
            end else if (state == LOAD) begin
                rows[load_row[RW-1:0]] <= fill_row;
                blocks_left            <= blocks_left + fill_count;
                load_row               <= (load_row == LAST_ROW) ? 5'd0 : load_row + 5'd1;
            end else if (accept && old_bit) begin
                rows[hit_row[RW-1:0]][hit_col] <= 1'b0;
                blocks_left                    <= blocks_left - {7'b0, |blocks_left};
            end
        end
    end
endmodule
